// File: rtl/dm_stage_pkg.sv
// Shared definitions for the data-memory pipeline stage: access-size encodings,
// memory geometry and the registered W-stage payload.
package dm_stage_pkg;

    typedef enum logic [2:0] {
        MEM_W  = 3'd0,
        MEM_H  = 3'd1,
        MEM_HU = 3'd2,
        MEM_B  = 3'd3,
        MEM_BU = 3'd4
    } memop_t;

    localparam int unsigned DM_WORDS      = 3072;
    localparam logic [31:0] DM_ADDR_LIMIT = 32'h0000_3000;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc8;
        logic [31:0] ao;
        logic [31:0] rd;
        logic [4:0]  a3;
        logic        regwrite;
        logic [3:0]  memtoreg;
        logic [1:0]  tnew;
    } w_payload_t;

endpackage

// File: rtl/dm_stage_ram.sv
// Data memory word array: byte-enable synchronous write, asynchronous read,
// synchronous clear of every word on reset.
module dm_ram
    import dm_stage_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        we,
    input  logic [3:0]  be,
    input  logic [11:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata
);

    logic [31:0] mem [DM_WORDS] = '{default: '0};

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < DM_WORDS; i++) mem[i] <= '0;
        end else if (we && (addr < 12'(DM_WORDS))) begin
            for (int unsigned b = 0; b < 4; b++)
                if (be[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
        end
    end

    assign rdata = (addr < 12'(DM_WORDS)) ? mem[addr] : '0;

endmodule

// File: rtl/dm_stage.sv
// M->W pipeline stage with data memory, lane select and load extension.
// Optional alignment checking enabled by defining DM_ALIGN_CHECK_EN.
module dm_stage
    import dm_stage_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  memop_m,
    input  logic        memwrite_m,
    input  logic [31:0] ao_m,
    input  logic [31:0] v2_m,
    input  logic [31:0] instr_m,
    input  logic [31:0] pc8_m,
    input  logic [4:0]  a3_m,
    input  logic        regwrite_m,
    input  logic [3:0]  memtoreg_m,
    input  logic [1:0]  Tnew_m,
    output logic [31:0] instr_w,
    output logic [31:0] pc8_w,
    output logic [31:0] ao_w,
    output logic [31:0] rd_w,
    output logic [4:0]  a3_w,
    output logic        regwrite_w,
    output logic [3:0]  memtoreg_w,
    output logic [1:0]  Tnew_w,
    output logic        err_w
);

    logic        in_range;
    logic        misalign;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] rword;
    logic [31:0] ldata;
    logic [15:0] hsel;
    logic [7:0]  bsel;
    w_payload_t  w_q = '0;

    assign in_range = ao_m < DM_ADDR_LIMIT;
    assign hsel     = ao_m[1] ? rword[31:16] : rword[15:0];
    assign bsel     = rword[8*ao_m[1:0] +: 8];

`ifdef DM_ALIGN_CHECK_EN
    always_comb begin
        misalign = 1'b0;
        case (memop_t'(memop_m))
            MEM_H, MEM_HU: misalign = ao_m[0];
            MEM_B, MEM_BU: misalign = 1'b0;
            default:       misalign = (ao_m[1:0] != 2'b00);
        endcase
    end
`else
    assign misalign = 1'b0;
`endif

    // Encodings 5-7 fall through to the word case.
    always_comb begin
        be    = 4'b1111;
        wdata = v2_m;
        ldata = rword;
        case (memop_t'(memop_m))
            MEM_H, MEM_HU: begin
                be    = ao_m[1] ? 4'b1100 : 4'b0011;
                wdata = {2{v2_m[15:0]}};
                ldata = (memop_m == MEM_H) ? {{16{hsel[15]}}, hsel} : {16'h0000, hsel};
            end
            MEM_B, MEM_BU: begin
                be    = 4'b0001 << ao_m[1:0];
                wdata = {4{v2_m[7:0]}};
                ldata = (memop_m == MEM_B) ? {{24{bsel[7]}}, bsel} : {24'h000000, bsel};
            end
            default: ;
        endcase
    end

    assign we = memwrite_m && in_range && !misalign;

    dm_ram u_ram (
        .clk   (clk),
        .reset (reset),
        .we    (we),
        .be    (be),
        .addr  (ao_m[13:2]),
        .wdata (wdata),
        .rdata (rword)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            w_q <= '0;
        end else begin
            w_q.instr    <= instr_m;
            w_q.pc8      <= pc8_m;
            w_q.ao       <= ao_m;
            w_q.rd       <= (in_range && !misalign) ? ldata : '0;
            w_q.a3       <= a3_m;
            w_q.regwrite <= regwrite_m && !misalign;
            w_q.memtoreg <= memtoreg_m;
            w_q.tnew     <= (Tnew_m == 2'd0) ? 2'd0 : Tnew_m - 2'd1;
        end
    end

`ifdef DM_ALIGN_CHECK_EN
    logic err_q = 1'b0;

    always_ff @(posedge clk) begin
        if (reset) err_q <= 1'b0;
        else       err_q <= misalign;
    end

    assign err_w = err_q;
`else
    assign err_w = 1'b0;
`endif

    assign instr_w    = w_q.instr;
    assign pc8_w      = w_q.pc8;
    assign ao_w       = w_q.ao;
    assign rd_w       = w_q.rd;
    assign a3_w       = w_q.a3;
    assign regwrite_w = w_q.regwrite;
    assign memtoreg_w = w_q.memtoreg;
    assign Tnew_w     = w_q.tnew;

endmodule

// File: tb/tb_dm_stage.sv
// Directed self-checking bench for dm_stage; alignment expectations follow
// DM_ALIGN_CHECK_EN when it is defined for the build.
module tb_dm_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  memop_m;
    logic        memwrite_m;
    logic [31:0] ao_m, v2_m, instr_m, pc8_m;
    logic [4:0]  a3_m;
    logic        regwrite_m;
    logic [3:0]  memtoreg_m;
    logic [1:0]  Tnew_m;
    logic [31:0] instr_w, pc8_w, ao_w, rd_w;
    logic [4:0]  a3_w;
    logic        regwrite_w;
    logic [3:0]  memtoreg_w;
    logic [1:0]  Tnew_w;
    logic        err_w;

    int total = 0;
    int bad   = 0;

    dm_stage dut (
        .clk(clk), .reset(reset), .memop_m(memop_m), .memwrite_m(memwrite_m),
        .ao_m(ao_m), .v2_m(v2_m), .instr_m(instr_m), .pc8_m(pc8_m), .a3_m(a3_m),
        .regwrite_m(regwrite_m), .memtoreg_m(memtoreg_m), .Tnew_m(Tnew_m),
        .instr_w(instr_w), .pc8_w(pc8_w), .ao_w(ao_w), .rd_w(rd_w), .a3_w(a3_w),
        .regwrite_w(regwrite_w), .memtoreg_w(memtoreg_w), .Tnew_w(Tnew_w), .err_w(err_w)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bubble();
        memop_m = 3'd0; memwrite_m = 1'b0; ao_m = '0; v2_m = '0; instr_m = '0;
        pc8_m = '0; a3_m = '0; regwrite_m = 1'b0; memtoreg_m = '0; Tnew_m = '0;
    endtask

    task automatic mem_op(input logic [2:0] op, input logic wr, input logic [31:0] addr,
                          input logic [31:0] data);
        memop_m = op; memwrite_m = wr; ao_m = addr; v2_m = data;
        tick();
    endtask

    task automatic do_reset();
        bubble();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        bubble();
        #1;
        total++;
        if ({instr_w, pc8_w, ao_w, rd_w, a3_w, regwrite_w, memtoreg_w, Tnew_w, err_w} !== '0) begin
            bad++; $display("FAIL time0_outputs rd_w=%h instr_w=%h exp=0", rd_w, instr_w);
        end
        instr_m = 32'hDEAD_BEEF; pc8_m = 32'h1234; a3_m = 5'd7; regwrite_m = 1'b1;
        memtoreg_m = 4'd3; Tnew_m = 2'd2; ao_m = 32'h10;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        total++;
        if ({instr_w, pc8_w, ao_w, rd_w, a3_w, regwrite_w, memtoreg_w, Tnew_w, err_w} !== '0) begin
            bad++; $display("FAIL reset_outputs instr_w=%h a3_w=%h exp=0", instr_w, a3_w);
        end
    endtask

    task automatic test_payload();
        do_reset();
        instr_m = 32'hAC00_0010; pc8_m = 32'h0000_3008; a3_m = 5'd5; regwrite_m = 1'b1;
        memtoreg_m = 4'd9; Tnew_m = 2'd2;
        mem_op(3'd0, 1'b1, 32'h10, 32'h8000_1234);
        total++;
        if ({instr_w, pc8_w, ao_w, a3_w, regwrite_w, memtoreg_w, Tnew_w} !==
            {32'hAC00_0010, 32'h0000_3008, 32'h10, 5'd5, 1'b1, 4'd9, 2'd1}) begin
            bad++; $display("FAIL payload instr_w=%h pc8_w=%h ao_w=%h a3_w=%0d Tnew_w=%0d exp ac000010/00003008/10/5/1",
                            instr_w, pc8_w, ao_w, a3_w, Tnew_w);
        end
        Tnew_m = 2'd0;
        mem_op(3'd0, 1'b0, 32'h10, 32'h0);
        total++;
        if (rd_w !== 32'h8000_1234) begin
            bad++; $display("FAIL sw_lw rd_w=%h exp=80001234", rd_w);
        end
        total++;
        if (Tnew_w !== 2'd0) begin
            bad++; $display("FAIL tnew_sat Tnew_w=%0d exp=0", Tnew_w);
        end
        Tnew_m = 2'd3;
        tick();
        total++;
        if (Tnew_w !== 2'd2) begin
            bad++; $display("FAIL tnew_dec Tnew_w=%0d exp=2", Tnew_w);
        end
    endtask

    task automatic test_byte();
        do_reset();
        mem_op(3'd3, 1'b1, 32'h13, 32'h1234_56AB);
        mem_op(3'd3, 1'b0, 32'h13, 32'h0);
        total++;
        if (rd_w !== 32'hFFFF_FFAB) begin bad++; $display("FAIL lb_13 rd_w=%h exp=ffffffab", rd_w); end
        mem_op(3'd4, 1'b0, 32'h13, 32'h0);
        total++;
        if (rd_w !== 32'h0000_00AB) begin bad++; $display("FAIL lbu_13 rd_w=%h exp=000000ab", rd_w); end
        mem_op(3'd0, 1'b0, 32'h10, 32'h0);
        total++;
        if (rd_w !== 32'hAB00_0000) begin bad++; $display("FAIL lw_10_after_sb rd_w=%h exp=ab000000", rd_w); end
        mem_op(3'd3, 1'b1, 32'h11, 32'h0000_0042);
        mem_op(3'd0, 1'b0, 32'h10, 32'h0);
        total++;
        if (rd_w !== 32'hAB00_4200) begin bad++; $display("FAIL lw_10_two_bytes rd_w=%h exp=ab004200", rd_w); end
        mem_op(3'd3, 1'b0, 32'h11, 32'h0);
        total++;
        if (rd_w !== 32'h0000_0042) begin bad++; $display("FAIL lb_11_pos rd_w=%h exp=00000042", rd_w); end
    endtask

    task automatic test_half();
        mem_op(3'd1, 1'b1, 32'h22, 32'hFFFF_9001);
        mem_op(3'd1, 1'b0, 32'h22, 32'h0);
        total++;
        if (rd_w !== 32'hFFFF_9001) begin bad++; $display("FAIL lh_22 rd_w=%h exp=ffff9001", rd_w); end
        mem_op(3'd2, 1'b0, 32'h22, 32'h0);
        total++;
        if (rd_w !== 32'h0000_9001) begin bad++; $display("FAIL lhu_22 rd_w=%h exp=00009001", rd_w); end
        mem_op(3'd0, 1'b0, 32'h20, 32'h0);
        total++;
        if (rd_w !== 32'h9001_0000) begin bad++; $display("FAIL lw_20_after_sh rd_w=%h exp=90010000", rd_w); end
        mem_op(3'd7, 1'b0, 32'h20, 32'h0);
        total++;
        if (rd_w !== 32'h9001_0000) begin bad++; $display("FAIL memop7_as_w rd_w=%h exp=90010000", rd_w); end
        mem_op(3'd1, 1'b0, 32'h20, 32'h0);
        total++;
        if (rd_w !== 32'h0000_0000) begin bad++; $display("FAIL lh_20_low rd_w=%h exp=00000000", rd_w); end
    endtask

    task automatic test_limit();
        do_reset();
        mem_op(3'd0, 1'b1, 32'h2FFC, 32'hDEAD_BEEF);
        mem_op(3'd0, 1'b1, 32'h3000, 32'h0000_0005);
        mem_op(3'd0, 1'b0, 32'h3000, 32'h0);
        total++;
        if (rd_w !== 32'h0) begin bad++; $display("FAIL lw_3000 rd_w=%h exp=00000000", rd_w); end
        mem_op(3'd0, 1'b0, 32'h2FFC, 32'h0);
        total++;
        if (rd_w !== 32'hDEAD_BEEF) begin bad++; $display("FAIL lw_2ffc rd_w=%h exp=deadbeef", rd_w); end
        mem_op(3'd0, 1'b0, 32'h0, 32'h0);
        total++;
        if (rd_w !== 32'h0) begin bad++; $display("FAIL lw_0_no_alias rd_w=%h exp=00000000", rd_w); end
    endtask

    task automatic test_reset_drop();
        mem_op(3'd0, 1'b1, 32'h44, 32'h0000_0099);
        instr_m = 32'h1111_1111; pc8_m = 32'h48; a3_m = 5'd3; regwrite_m = 1'b1; Tnew_m = 2'd2;
        memop_m = 3'd0; memwrite_m = 1'b1; ao_m = 32'h40; v2_m = 32'h0000_0077;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        total++;
        if ({instr_w, pc8_w, ao_w, rd_w, a3_w, regwrite_w, memtoreg_w, Tnew_w, err_w} !== '0) begin
            bad++; $display("FAIL reset_drop_outputs instr_w=%h ao_w=%h exp=0", instr_w, ao_w);
        end
        bubble();
        mem_op(3'd0, 1'b0, 32'h40, 32'h0);
        total++;
        if (rd_w !== 32'h0) begin bad++; $display("FAIL reset_drop_lw40 rd_w=%h exp=00000000", rd_w); end
        mem_op(3'd0, 1'b0, 32'h44, 32'h0);
        total++;
        if (rd_w !== 32'h0) begin bad++; $display("FAIL reset_clear_lw44 rd_w=%h exp=00000000", rd_w); end
    endtask

    task automatic test_misalign();
        do_reset();
        mem_op(3'd0, 1'b1, 32'h40, 32'h1122_3344);
        regwrite_m = 1'b1;
        mem_op(3'd0, 1'b0, 32'h42, 32'h0);
`ifdef DM_ALIGN_CHECK_EN
        total++;
        if ({err_w, regwrite_w, rd_w} !== {1'b1, 1'b0, 32'h0}) begin
            bad++; $display("FAIL misalign_lw42 err_w=%b regwrite_w=%b rd_w=%h exp 1/0/00000000",
                            err_w, regwrite_w, rd_w);
        end
        bubble();
        tick();
        total++;
        if (err_w !== 1'b0) begin bad++; $display("FAIL misalign_one_cycle err_w=%b exp=0", err_w); end
`else
        total++;
        if ({err_w, regwrite_w, rd_w} !== {1'b0, 1'b1, 32'h1122_3344}) begin
            bad++; $display("FAIL noalign_lw42 err_w=%b regwrite_w=%b rd_w=%h exp 0/1/11223344",
                            err_w, regwrite_w, rd_w);
        end
        bubble();
        mem_op(3'd1, 1'b1, 32'h43, 32'h0000_ABCD);
        mem_op(3'd0, 1'b0, 32'h40, 32'h0);
        total++;
        if (rd_w !== 32'hABCD_3344) begin bad++; $display("FAIL noalign_sh43 rd_w=%h exp=abcd3344", rd_w); end
`endif
    endtask

    initial begin
        test_reset();
        test_payload();
        test_byte();
        test_half();
        test_limit();
        test_reset_drop();
        test_misalign();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dm_stage.md
DM_STAGE -- requirements
Module: dm_stage

Interface
REQ-001 SHALL: clk  in  1  clock; reset reset, synchronous, active-high; clock clk.
REQ-002 SHALL: reset  in  1  sync active-high reset.
REQ-003 SHALL: memop_m  in  3  access size: 0 W, 1 H, 2 HU, 3 B, 4 BU; 5-7 treated as W.
REQ-004 SHALL: memwrite_m  in  1  store enable.
REQ-005 SHALL: ao_m  in  32  byte address / ALU result.
REQ-006 SHALL: v2_m  in  32  store data, right-aligned.
REQ-007 SHALL: instr_m, pc8_m  in  32 each; a3_m  in  5; regwrite_m  in  1; memtoreg_m  in  4; Tnew_m  in  2  (pipeline payload).
REQ-008 SHALL: instr_w, pc8_w, ao_w, rd_w  out  32 each; a3_w  out  5; regwrite_w  out  1; memtoreg_w  out  4; Tnew_w  out  2; err_w  out  1.

Function
REQ-009 SHALL: data memory 3072 x 32-bit words, byte addresses 0x0000-0x2FFF, word index ao_m[13:2].
REQ-010 SHALL: store commits at the posedge where memwrite_m=1 and reset=0; W writes all 4 bytes, H writes halfword ao_m[1], B writes byte ao_m[1:0], lane data from v2_m[15:0]/v2_m[7:0].
REQ-011 SHALL: load data read combinationally from the array, lane-selected by ao_m[1:0], sign- (H, B) or zero- (HU, BU) extended, registered into rd_w at the same edge; load-to-rd_w latency 1 cycle.
REQ-012 SHALL: store in cycle N visible to a load to the same word in cycle N+1.
REQ-013 SHALL: address >= 0x3000: store suppressed, rd_w loaded with 0.
REQ-014 SHALL: every posedge (no reset) copy instr, pc8, ao, a3, regwrite, memtoreg to the _w outputs.
REQ-015 SHALL: Tnew_w = Tnew_m - 1, saturating at 0.
REQ-016 SHALL: no stall/flush input; a bubble enters as all-zero payload (memwrite_m=0, regwrite_m=0).

Reset
REQ-017 SHALL: on reset edge all _w outputs, rd_w and err_w become 0.
REQ-018 SHALL: on reset edge every memory word becomes 0; a store present in M at that edge is dropped.
REQ-019 SHALL: all outputs and memory also 0 from time zero before the first edge.

Configuration
REQ-020 SHALL: macro DM_ALIGN_CHECK_EN defined: misaligned access (W with ao_m[1:0]!=0, H/HU with ao_m[0]=1) suppresses the store, forces regwrite_w=0 and rd_w=0, and sets err_w=1 for that one W-stage cycle.
REQ-021 SHALL: macro undefined: no alignment check, low address bits ignored for W / H lane select as in REQ-010/011, err_w tied 0.

Structure
REQ-022 SHALL: shared package holds memop encodings, DM_WORDS=3072, DM_ADDR_LIMIT=0x3000.
REQ-023 SHALL: one sub-module dm_ram (word array, byte-enable write port, async read port, sync clear); lane select/extension and W register stay in dm_stage.

Verification
REQ-024 SHALL: sw 0x8000_1234 @0x10, then lw @0x10 next cycle -> rd_w=0x8000_1234 one cycle after the load.
REQ-025 SHALL: sb 0xAB @0x13 over word 0 -> lb @0x13 gives 0xFFFF_FFAB, lbu gives 0x0000_00AB, lw @0x10 gives 0xAB00_0000.
REQ-026 SHALL: sh 0x9001 @0x22 -> lh @0x22 = 0xFFFF_9001, lhu = 0x0000_9001, lw @0x20 = 0x9001_0000.
REQ-027 SHALL: sw 0x5 @0x3000 -> no array change; lw @0x3000 gives rd_w=0.
REQ-028 SHALL: reset asserted in the cycle a sw @0x40 is in M -> after reset lw @0x40 = 0, all _w outputs 0.
REQ-029 SHALL: with DM_ALIGN_CHECK_EN, lw @0x42 regwrite_m=1 -> err_w=1, regwrite_w=0, rd_w=0 for one cycle; without macro, err_w=0 and rd_w = word @0x40.
